// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: IDLE -> REQ -> WAIT -> HOLD.
// Define IFU_MISALIGN_CHECK_EN to reject misaligned redirects via sticky Fetch_err.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        Imem_req_valid,
  input  logic        Imem_req_ready,
  output logic [31:0] Imem_addr,
  input  logic        Imem_resp_valid,
  input  logic [31:0] Imem_rdata,
  output logic        Inst_valid,
  input  logic        Inst_ready,
  output logic [31:0] Inst,
  output logic [31:0] Inst_pc,
  input  logic        Redirect_valid,
  input  logic [31:0] Redirect_pc,
  output logic        Fetch_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        flush_q, flush_d;
  logic        err_q, err_d;
  logic        redir;
  logic [31:0] target;

`ifdef IFU_MISALIGN_CHECK_EN
  assign redir  = Redirect_valid && (Redirect_pc[1:0] == 2'b00);
  assign target = Redirect_pc;
  assign err_d  = err_q | (Redirect_valid && (Redirect_pc[1:0] != 2'b00));
`else
  assign redir  = Redirect_valid;
  assign target = Redirect_pc & ~32'h3;
  assign err_d  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    flush_d   = flush_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redir) pc_d = target;
      end
      REQ: begin
        if (redir) pc_d = target;
        if (Imem_req_ready) begin
          state_d = WAIT;
          flush_d = redir;
        end
      end
      WAIT: begin
        if (redir) begin
          pc_d    = target;
          flush_d = 1'b1;
          if (Imem_resp_valid) begin
            state_d = REQ;
            flush_d = 1'b0;
          end
        end else if (Imem_resp_valid) begin
          flush_d = 1'b0;
          // A flushed response belongs to a stale pc: refetch instead
          if (flush_q) begin
            state_d = REQ;
          end else begin
            state_d   = HOLD;
            inst_d    = Imem_rdata;
            inst_pc_d = pc_q;
          end
        end
      end
      HOLD: begin
        if (redir) begin
          pc_d    = target;
          state_d = REQ;
        end else if (Inst_ready) begin
          pc_d    = inst_pc_q + 32'd4;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0000_0013;
      inst_pc_q <= 32'h0;
      flush_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      flush_q   <= flush_d;
      err_q     <= err_d;
    end
  end

  assign Imem_req_valid = (state_q == REQ);
  assign Imem_addr      = pc_q;
  assign Inst_valid     = (state_q == HOLD);
  assign Inst           = inst_q;
  assign Inst_pc        = inst_pc_q;
  assign Fetch_err      = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a 1-cycle (stallable) instruction memory.
module tb_ifu_fetch;
  localparam logic [31:0] K = 32'h5A5A_0F0F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Imem_req_valid;
  logic        Imem_req_ready = 1'b1;
  logic [31:0] Imem_addr;
  logic        Imem_resp_valid = 1'b0;
  logic [31:0] Imem_rdata = 32'h0;
  logic        Inst_valid;
  logic        Inst_ready = 1'b0;
  logic [31:0] Inst;
  logic [31:0] Inst_pc;
  logic        Redirect_valid = 1'b0;
  logic [31:0] Redirect_pc = 32'h0;
  logic        Fetch_err;

  logic        stall = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'h0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] held_inst, held_pc;

  ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .Imem_req_valid(Imem_req_valid), .Imem_req_ready(Imem_req_ready),
    .Imem_addr(Imem_addr), .Imem_resp_valid(Imem_resp_valid),
    .Imem_rdata(Imem_rdata), .Inst_valid(Inst_valid),
    .Inst_ready(Inst_ready), .Inst(Inst), .Inst_pc(Inst_pc),
    .Redirect_valid(Redirect_valid), .Redirect_pc(Redirect_pc),
    .Fetch_err(Fetch_err)
  );

  always #5 clk = ~clk;

  // Memory: word = addr ^ K, answered the cycle after acceptance unless stalled
  always @(posedge clk) begin
    Imem_resp_valid <= 1'b0;
    if (Imem_req_valid && Imem_req_ready) begin
      if (stall) begin
        pend  <= 1'b1;
        paddr <= Imem_addr;
      end else begin
        Imem_resp_valid <= 1'b1;
        Imem_rdata      <= Imem_addr ^ K;
        pend            <= 1'b0;
      end
    end else if (pend && !stall) begin
      Imem_resp_valid <= 1'b1;
      Imem_rdata      <= paddr ^ K;
      pend            <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_inst(input string tag, input logic [31:0] pc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (Inst_valid === 1'b1) seen = 1'b1;
    end
    chk({tag, "_seen"}, {31'h0, seen}, 32'h1);
    chk({tag, "_pc"}, Inst_pc, pc);
    chk({tag, "_inst"}, Inst, pc ^ K);
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    step;
    chk("rst_reqv", {31'h0, Imem_req_valid}, 32'h0);
    chk("rst_instv", {31'h0, Inst_valid}, 32'h0);
    chk("rst_inst", Inst, 32'h0000_0013);
    chk("rst_instpc", Inst_pc, 32'h0);
    chk("rst_err", {31'h0, Fetch_err}, 32'h0);
    chk("rst_addr", Imem_addr, 32'h8000_0000);
    rst = 1'b0;

    // First fetch: accept in N, resp in N+1, Inst_valid in N+2
    step;
    chk("n_reqv", {31'h0, Imem_req_valid}, 32'h1);
    chk("n_addr", Imem_addr, 32'h8000_0000);
    step;
    chk("n1_instv", {31'h0, Inst_valid}, 32'h0);
    chk("n1_reqv", {31'h0, Imem_req_valid}, 32'h0);
    step;
    chk("n2_instv", {31'h0, Inst_valid}, 32'h1);
    chk("n2_pc", Inst_pc, 32'h8000_0000);
    chk("n2_inst", Inst, 32'h8000_0000 ^ K);

    // Decode stalls for 5 cycles
    held_inst = Inst;
    held_pc   = Inst_pc;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("hold_v", {31'h0, Inst_valid}, 32'h1);
      chk("hold_inst", Inst, held_inst);
      chk("hold_pc", Inst_pc, held_pc);
      chk("hold_noreq", {31'h0, Imem_req_valid}, 32'h0);
    end
    Inst_ready = 1'b1;
    wait_inst("seq4", 32'h8000_0004);
    wait_inst("seq8", 32'h8000_0008);

    // Redirect while waiting on a response that arrives that cycle
    step;
    chk("req_c_addr", Imem_addr, 32'h8000_000C);
    step;
    Redirect_valid = 1'b1;
    Redirect_pc    = 32'h8000_0100;
    step;
    Redirect_valid = 1'b0;
    chk("rw_reqv", {31'h0, Imem_req_valid}, 32'h1);
    chk("rw_addr", Imem_addr, 32'h8000_0100);
    chk("rw_instv", {31'h0, Inst_valid}, 32'h0);
    wait_inst("rw_fetch", 32'h8000_0100);

    // Redirect while waiting, response comes later and must be flushed
    step;
    stall = 1'b1;
    step;
    Redirect_valid = 1'b1;
    Redirect_pc    = 32'h8000_0300;
    step;
    Redirect_valid = 1'b0;
    stall          = 1'b0;
    chk("fl_instv0", {31'h0, Inst_valid}, 32'h0);
    step;
    chk("fl_instv1", {31'h0, Inst_valid}, 32'h0);
    step;
    chk("fl_instv2", {31'h0, Inst_valid}, 32'h0);
    chk("fl_reqv", {31'h0, Imem_req_valid}, 32'h1);
    chk("fl_addr", Imem_addr, 32'h8000_0300);
    wait_inst("fl_fetch", 32'h8000_0300);

    // Redirect coinciding with the HOLD handshake
    Redirect_valid = 1'b1;
    Redirect_pc    = 32'h8000_0200;
    step;
    Redirect_valid = 1'b0;
    chk("rh_addr", Imem_addr, 32'h8000_0200);
    chk("rh_instv", {31'h0, Inst_valid}, 32'h0);

    // Redirect in HOLD without decode consuming
    Inst_ready = 1'b0;
    wait_inst("rh_fetch", 32'h8000_0200);
    Redirect_valid = 1'b1;
    Redirect_pc    = 32'h8000_0400;
    step;
    Redirect_valid = 1'b0;
    Inst_ready     = 1'b1;
    chk("rd_instv", {31'h0, Inst_valid}, 32'h0);
    chk("rd_addr", Imem_addr, 32'h8000_0400);

    // Redirect in REQ while memory is not ready
    Imem_req_ready = 1'b0;
    step;
    Redirect_valid = 1'b1;
    Redirect_pc    = 32'h8000_0500;
    step;
    Redirect_valid = 1'b0;
    chk("rq_reqv", {31'h0, Imem_req_valid}, 32'h1);
    chk("rq_addr", Imem_addr, 32'h8000_0500);
    Imem_req_ready = 1'b1;
    wait_inst("rq_fetch", 32'h8000_0500);

    // Misaligned redirect issued as a request is accepted
    step;
    Redirect_valid = 1'b1;
    Redirect_pc    = 32'h8000_0102;
    step;
    Redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis_err", {31'h0, Fetch_err}, 32'h1);
    wait_inst("mis_a", 32'h8000_0504);
    wait_inst("mis_b", 32'h8000_0508);
    chk("mis_sticky", {31'h0, Fetch_err}, 32'h1);
`else
    chk("mis_err", {31'h0, Fetch_err}, 32'h0);
    wait_inst("mis_a", 32'h8000_0100);
    wait_inst("mis_b", 32'h8000_0104);
`endif

    // Reset in the middle of an outstanding fetch
    step;
    stall = 1'b1;
    step;
    rst = 1'b1;
    #1;
    chk("mr_reqv", {31'h0, Imem_req_valid}, 32'h0);
    chk("mr_instv", {31'h0, Inst_valid}, 32'h0);
    chk("mr_inst", Inst, 32'h0000_0013);
    chk("mr_pc", Inst_pc, 32'h0);
    chk("mr_err", {31'h0, Fetch_err}, 32'h0);
    chk("mr_addr", Imem_addr, 32'h8000_0000);
    step;
    rst   = 1'b0;
    stall = 1'b0;
    wait_inst("mr_fetch", 32'h8000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
